// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and default parameter constants for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state (idle / grant held)
//   Def*        : default values for NUM_REQ, FIFO_WIDTH and MAX_BURST
package fifo_arb_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } arb_state_e;

   localparam int unsigned DefNumReq    = 4;
   localparam int unsigned DefFifoWidth = 16;
   localparam int unsigned DefMaxBurst  = 4;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans i_valid upward starting at i_ptr,
//   wrapping from NUM_REQ-1 to 0, and returns the first asserted index.
//   Ports:
//     i_valid : per-requester valid vector
//     i_ptr   : index with highest priority this round
//     o_idx   : winning index (0 when nothing is valid)
//     o_any   : at least one requester is valid
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DefNumReq
) (
   input  logic [NUM_REQ-1:0]         i_valid,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   output logic [$clog2(NUM_REQ)-1:0] o_idx,
   output logic                       o_any
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   logic [IdxW-1:0] w_cand;

   // Walk from the farthest offset back to offset 0 so the closest valid
   // index to i_ptr is the last one written. NUM_REQ is a power of two, so
   // the truncating add wraps for free.
   always_comb begin
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         w_cand = i_ptr + IdxW'(i);
         if (i_valid[w_cand]) begin
            o_idx = w_cand;
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter letting NUM_REQ producers write bursts into one shared
//   FIFO. Idle cycles arbitrate; a grant then streams up to MAX_BURST beats
//   from the owner until its last beat, the beat limit, or the owner withdraws.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     req_valid     : per-producer beat valid
//     req_data      : producer k data at [k*FIFO_WIDTH +: FIFO_WIDTH]
//     req_last      : per-producer final-beat marker
//     req_ready     : beat from producer k accepted this cycle
//     is_fifo_full  : shared FIFO full flag
//     i_push        : shared FIFO write strobe
//     in_fifo       : shared FIFO write data
//     grant_id      : current owner, valid while busy
//     busy          : a grant is held
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = DefNumReq,
   parameter int unsigned FIFO_WIDTH = DefFifoWidth,
   parameter int unsigned MAX_BURST  = DefMaxBurst
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            is_fifo_full,
   output logic                            i_push,
   output logic [FIFO_WIDTH-1:0]           in_fifo,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            busy
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

   arb_state_e      r_state, w_state_nxt;
   logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_nxt;
   logic [IdxW-1:0] r_grant_id, w_grant_id_nxt;
   logic [CntW-1:0] r_beat_cnt, w_beat_cnt_nxt, w_beat_cnt_inc;
   logic [IdxW-1:0] w_pick_idx;
   logic            w_pick_any;
   logic            w_owner_valid, w_owner_last, w_xfer, w_burst_end;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_valid (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // Beat decode and outputs
   always_comb begin
      busy           = (r_state == StGrant);
      w_owner_valid  = req_valid[r_grant_id];
      w_owner_last   = req_last[r_grant_id];
      w_xfer         = busy & w_owner_valid & ~is_fifo_full;
      w_beat_cnt_inc = r_beat_cnt + 1'b1;
      // A withdrawn owner ends the burst even while the FIFO is full.
      w_burst_end    = busy & (~w_owner_valid |
                               (w_xfer & (w_owner_last |
                                          (w_beat_cnt_inc == CntW'(MAX_BURST)))));
      i_push               = w_xfer;
      req_ready            = '0;
      req_ready[r_grant_id] = w_xfer;
      in_fifo              = busy ? req_data[int'(r_grant_id) * FIFO_WIDTH +: FIFO_WIDTH]
                                  : '0;
      grant_id             = r_grant_id;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_grant_id_nxt = r_grant_id;
      w_beat_cnt_nxt = r_beat_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_pick_any) begin
               w_state_nxt    = StGrant;
               w_grant_id_nxt = w_pick_idx;
               w_beat_cnt_nxt = '0;
            end
         end
         StGrant: begin
            if (w_burst_end) begin
               w_state_nxt  = StIdle;
               w_rr_ptr_nxt = r_grant_id + 1'b1;
            end else if (w_xfer) begin
               w_beat_cnt_nxt = w_beat_cnt_inc;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=4, FIFO_WIDTH=16, MAX_BURST=4).
//   Producers are modelled as beat arrays that advance on req_ready; expected
//   pushes {id, data} are queued in arbitration order and popped on i_push.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int W  = 16;
   localparam int MB = 4;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic [NR-1:0]     req_valid;
   logic [NR*W-1:0]   req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic              full;
   logic              i_push;
   logic [W-1:0]      in_fifo;
   logic [1:0]        grant_id;
   logic              busy;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .FIFO_WIDTH (W),
      .MAX_BURST  (MB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .is_fifo_full (full),
      .i_push       (i_push),
      .in_fifo      (in_fifo),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int          errors;
   int          checks;
   int          cyc;
   int          n_push;
   int          last_push_cyc;
   int          tnum;
   logic        s_busy;
   logic        s_push;
   logic [17:0] sb[$];
   logic [15:0] mem_d[NR][16];
   logic        mem_l[NR][16];
   int          head[NR];
   int          tail[NR];
   logic        en[NR];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NR; k++) begin
         if (head[k] < tail[k]) begin
            req_valid[k]        = en[k];
            req_data[k*W +: W]  = mem_d[k][head[k]];
            req_last[k]         = mem_l[k][head[k]];
         end else begin
            req_valid[k]        = 1'b0;
            req_data[k*W +: W]  = '0;
            req_last[k]         = 1'b0;
         end
      end
   endtask

   task automatic clear_all();
      for (int k = 0; k < NR; k++) begin
         head[k] = 0;
         tail[k] = 0;
         en[k]   = 1'b1;
      end
   endtask

   task automatic load(input int k, input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         mem_d[k][tail[k]] = {4'(tnum), 4'(k), 8'(tail[k])};
         mem_l[k][tail[k]] = with_last && (i == n - 1);
         tail[k]++;
      end
   endtask

   task automatic expect_beats(input int k, input int first, input int n);
      for (int i = 0; i < n; i++) sb.push_back({2'(k), mem_d[k][first + i]});
   endtask

   // One clock: sample at negedge, score any push, then update producers.
   task automatic tick();
      logic [NR-1:0] acc;
      logic [17:0]   e;
      @(negedge clk);
      cyc++;
      s_busy = busy;
      s_push = i_push;
      acc    = req_ready;
      if (i_push === 1'b1) begin
         n_push++;
         last_push_cyc = cyc;
         if (sb.size() == 0) begin
            check("unexpected_push", 32'(i_push), 32'd0);
         end else begin
            e = sb.pop_front();
            check("push_data", 32'(in_fifo), 32'(e[15:0]));
            check("push_grant", 32'(grant_id), 32'(e[17:16]));
            check("push_ready", 32'(req_ready), 32'd1 << e[17:16]);
         end
      end else begin
         check("ready_no_push", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (acc[k] && head[k] < tail[k]) head[k]++;
      drive();
   endtask

   task automatic wait_pushes(input string tag, input int target, input int budget);
      int n = 0;
      while (n_push < target && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(n_push >= target), 32'd1);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_drain"}, 32'(sb.size()), 32'd0);
      tick();
      tick();
      check({tag, "_idle"}, 32'(s_busy), 32'd0);
   endtask

   // Outputs must drop as soon as reset asserts, with producers still driving.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_push", 32'(i_push), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(in_fifo), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      full = 1'b0;
      clear_all();
      drive();
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [4:0] pat;
      int f0, f1, f2, f3, base, t0;
      errors = 0; checks = 0; cyc = 0; n_push = 0; last_push_cyc = 0; tnum = 0;
      full = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      clear_all();
      drive();
      #2;
      do_reset();

      // Single producer, 3-beat burst: idle, three pushes, idle.
      tnum = 1;
      load(0, 3, 1'b1);
      expect_beats(0, 0, 3);
      drive();
      pat = 5'b01110;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("t1_busy_c%0d", c), 32'(s_busy), 32'(pat[c]));
         check($sformatf("t1_push_c%0d", c), 32'(s_push), 32'(pat[c]));
      end
      check("t1_sb", 32'(sb.size()), 32'd0);
      // rr_ptr is now 1: producer 1 beats producer 0.
      f0 = tail[0]; load(0, 1, 1'b1);
      f1 = tail[1]; load(1, 1, 1'b1);
      expect_beats(1, f1, 1);
      expect_beats(0, f0, 1);
      drive();
      drain("t1b", 20);

      // All four continuously valid, no last: 0,1,2,3,0 with one bubble each.
      do_reset();
      tnum = 2;
      for (int k = 0; k < NR; k++) load(k, 8, 1'b0);
      for (int k = 0; k < NR; k++) expect_beats(k, 0, 4);
      expect_beats(0, 4, 4);
      drive();
      base = n_push;
      wait_pushes("t2_first", base + 1, 10);
      t0 = last_push_cyc;
      wait_pushes("t2_all", base + 20, 60);
      check("t2_span", 32'(last_push_cyc - t0), 32'd23);
      check("t2_sb", 32'(sb.size()), 32'd0);

      // Producer 2 stalled by a full FIFO for three cycles mid-burst.
      do_reset();
      tnum = 3;
      load(2, 4, 1'b1);
      expect_beats(2, 0, 4);
      drive();
      wait_pushes("t3_two", n_push + 2, 10);
      full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t3_stall_push", 32'(s_push), 32'd0);
         check("t3_stall_busy", 32'(s_busy), 32'd1);
         check("t3_stall_grant", 32'(grant_id), 32'd2);
      end
      full = 1'b0;
      drain("t3", 20);

      // rr_ptr is 3: producer 3 first, then the pointer wraps to 0.
      tnum = 4;
      f0 = tail[0]; load(0, 2, 1'b1);
      f3 = tail[3]; load(3, 2, 1'b1);
      expect_beats(3, f3, 2);
      expect_beats(0, f0, 2);
      drive();
      drain("t4", 20);

      // Owner withdraws after one beat.
      tnum = 5;
      f1 = tail[1]; load(1, 3, 1'b0);
      expect_beats(1, f1, 1);
      drive();
      wait_pushes("t5_first", n_push + 1, 10);
      en[1] = 1'b0;
      drive();
      tick();
      check("t5_wd_push", 32'(s_push), 32'd0);
      check("t5_wd_busy", 32'(s_busy), 32'd1);
      tick();
      check("t5_idle", 32'(s_busy), 32'd0);
      head[1] = tail[1];
      en[1] = 1'b1;
      // rr_ptr advanced to 2: producer 2 ahead of producer 1.
      f1 = tail[1]; load(1, 1, 1'b1);
      f2 = tail[2]; load(2, 1, 1'b1);
      expect_beats(2, f2, 1);
      expect_beats(1, f1, 1);
      drive();
      drain("t5b", 20);

      // Reset on beat 2 of a 4-beat burst.
      tnum = 6;
      f1 = tail[1]; load(1, 4, 1'b0);
      expect_beats(1, f1, 4);
      drive();
      wait_pushes("t6_two", n_push + 2, 10);
      do_reset();
      load(0, 1, 1'b1);
      load(3, 1, 1'b1);
      expect_beats(0, 0, 1);
      expect_beats(3, 0, 1);
      drive();
      tick();
      check("t6_rel_push", 32'(s_push), 32'd0);
      check("t6_rel_busy", 32'(s_busy), 32'd0);
      drain("t6", 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
